mux2x1_rr_arbiter: RTL and testbench



---
 rtl/mux2x1_rr_arbiter_pkg.sv | 32 +++
 rtl/mux2x1_rr_arbiter_hold_counter.sv | 33 +++
 rtl/mux2x1_rr_arbiter.sv | 144 ++++++++++++++
 tb/tb_mux2x1_rr_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mux2x1_rr_arbiter_pkg.sv
// Shared definitions for the 2:1 mux round-robin arbiter.
//   - grant FSM state encodings
//   - mux select constants (s=0 -> a0, s=1 -> a1)
//   - default hold-counter width and maximum-hold limit
//   - helper returning the competing request for the current owner
package mux2x1_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_G0   = 2'b01,
    ST_G1   = 2'b10
  } state_t;

  localparam logic SEL_A0 = 1'b0;
  localparam logic SEL_A1 = 1'b1;

  localparam int CNT_W_DEFAULT    = 8;
  localparam int MAX_HOLD_DEFAULT = 16;

  // Request of the channel that does NOT currently own the mux.
  function automatic logic other_req(state_t st, logic req0, logic req1);
    logic w_other;
    w_other = 1'b0;
    case (st)
      ST_G0:   w_other = req1;
      ST_G1:   w_other = req0;
      default: w_other = 1'b0;
    endcase
    return w_other;
  endfunction

endpackage

// File: rtl/mux2x1_rr_arbiter_hold_counter.sv
// hold_counter: counts consecutive cycles the current owner keeps the mux
// while the other channel waits. Saturates at all-ones instead of wrapping.
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset (count -> 0)
//   i_clr  - clear to zero (wins over i_en)
//   i_en   - increment by one unless saturated
//   o_cnt  - current count
module hold_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mux2x1_rr_arbiter.sv
// mux2x1_rr_arbiter: round-robin arbiter driving the select line of a 2:1
// dataflow mux (channel 0 -> a0, channel 1 -> a1), with an optional
// maximum-hold timeout. Every output comes straight from a flop.
// Ports:
//   clk          - system clock, rising edge
//   rst          - synchronous active-high reset
//   req0, req1   - level requests, held until the channel is done
//   gnt0, gnt1   - channel owns the mux (never both high)
//   s            - mux select, holds its last value while idle
//   sel_valid    - gnt0 | gnt1
//   switch_pulse - first cycle of a grant whose previous owner differed
//
// state   | meaning
// --------+-------------------------------------------
// ST_IDLE | no owner, s keeps previous value
// ST_G0   | channel 0 owns the mux (s = a0)
// ST_G1   | channel 1 owns the mux (s = a1)
module mux2x1_rr_arbiter
  import mux2x1_rr_arbiter_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic s,
  output logic sel_valid,
  output logic switch_pulse
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_last;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_s;
  logic             r_sel_valid;
  logic             r_switch;

  logic             w_gnt0_nxt;
  logic             w_gnt1_nxt;
  logic             w_s_nxt;
  logic             w_last_nxt;
  logic             w_switch_nxt;
  logic             w_timeout;
  logic             w_cnt_en;
  logic [CNT_W-1:0] w_hold_cnt;

  // Owner has held for MAX_HOLD cycles of contention once this is true.
  assign w_timeout = (MAX_HOLD != 0) && (w_hold_cnt == HOLD_LAST);
  assign w_cnt_en  = other_req(r_state, req0, req1);

  hold_counter #(
    .CNT_W (CNT_W)
  ) u_hold_counter (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_switch_nxt),
    .i_en  (w_cnt_en),
    .o_cnt (w_hold_cnt)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_last      <= 1'b1;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_s         <= SEL_A0;
      r_sel_valid <= 1'b0;
      r_switch    <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_last      <= w_last_nxt;
      r_gnt0      <= w_gnt0_nxt;
      r_gnt1      <= w_gnt1_nxt;
      r_s         <= w_s_nxt;
      r_sel_valid <= w_gnt0_nxt | w_gnt1_nxt;
      r_switch    <= w_switch_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req0 && req1) begin
          // r_last names the previous owner; the other one wins the tie.
          w_next_state = r_last ? ST_G0 : ST_G1;
        end else if (req0) begin
          w_next_state = ST_G0;
        end else if (req1) begin
          w_next_state = ST_G1;
        end
      end
      ST_G0: begin
        if (!req0) begin
          w_next_state = req1 ? ST_G1 : ST_IDLE;
        end else if (req1 && w_timeout) begin
          w_next_state = ST_G1;
        end
      end
      ST_G1: begin
        if (!req1) begin
          w_next_state = req0 ? ST_G0 : ST_IDLE;
        end else if (req0 && w_timeout) begin
          w_next_state = ST_G0;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output logic: values the output flops take at the next edge
  always_comb begin
    w_gnt0_nxt   = (w_next_state == ST_G0);
    w_gnt1_nxt   = (w_next_state == ST_G1);
    w_switch_nxt = (w_next_state != ST_IDLE) && (w_next_state != r_state);
    w_s_nxt      = r_s;
    w_last_nxt   = r_last;
    if (w_gnt0_nxt) begin
      w_s_nxt    = SEL_A0;
      w_last_nxt = 1'b0;
    end else if (w_gnt1_nxt) begin
      w_s_nxt    = SEL_A1;
      w_last_nxt = 1'b1;
    end
  end

  assign gnt0         = r_gnt0;
  assign gnt1         = r_gnt1;
  assign s            = r_s;
  assign sel_valid    = r_sel_valid;
  assign switch_pulse = r_switch;

endmodule

// File: tb/tb_mux2x1_rr_arbiter.sv
// Scoreboard bench for mux2x1_rr_arbiter. Two instances: dut_a with
// MAX_HOLD=4, dut_b with the timeout disabled (MAX_HOLD=0). Each step drives
// one instance, and after the sampling edge pushes the hand-computed outputs;
// a monitor pops and compares on the falling edge.
module tb_mux2x1_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic a_req0 = 1'b0, a_req1 = 1'b0, b_req0 = 1'b0, b_req1 = 1'b0;
  logic a_gnt0, a_gnt1, a_s, a_sv, a_sw;
  logic b_gnt0, b_gnt1, b_s, b_sv, b_sw;

  mux2x1_rr_arbiter #(.CNT_W(8), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .req0(a_req0), .req1(a_req1),
    .gnt0(a_gnt0), .gnt1(a_gnt1), .s(a_s), .sel_valid(a_sv), .switch_pulse(a_sw)
  );

  mux2x1_rr_arbiter #(.CNT_W(8), .MAX_HOLD(0)) dut_b (
    .clk(clk), .rst(rst), .req0(b_req0), .req1(b_req1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .s(b_s), .sel_valid(b_sv), .switch_pulse(b_sw)
  );

  typedef struct {
    bit   use_b;
    logic g0;
    logic g1;
    logic s;
    logic sw;
    int   id;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   step_id = 0;

  localparam int A = 0;
  localparam int B = 1;

  task automatic chk(input string name, input int id, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %b expected %b", name, id, act, exp);
  endtask

  // Monitor: compare every queued expectation against the selected instance.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.use_b) begin
          chk("b_gnt0", e.id, b_gnt0, e.g0);
          chk("b_gnt1", e.id, b_gnt1, e.g1);
          chk("b_s", e.id, b_s, e.s);
          chk("b_sel_valid", e.id, b_sv, e.g0 | e.g1);
          chk("b_switch_pulse", e.id, b_sw, e.sw);
        end else begin
          chk("a_gnt0", e.id, a_gnt0, e.g0);
          chk("a_gnt1", e.id, a_gnt1, e.g1);
          chk("a_s", e.id, a_s, e.s);
          chk("a_sel_valid", e.id, a_sv, e.g0 | e.g1);
          chk("a_switch_pulse", e.id, a_sw, e.sw);
        end
      end
    end
  end

  // Drive one cycle of inputs, then queue the outputs expected after the edge.
  task automatic step(input int d, input int r, input int q0, input int q1,
                      input int eg0, input int eg1, input int es, input int esw);
    exp_t e;
    rst    = (r != 0);
    a_req0 = (d == A) && (q0 != 0);
    a_req1 = (d == A) && (q1 != 0);
    b_req0 = (d == B) && (q0 != 0);
    b_req1 = (d == B) && (q1 != 0);
    @(posedge clk);
    step_id++;
    e.use_b = (d == B);
    e.g0    = (eg0 != 0);
    e.g1    = (eg1 != 0);
    e.s     = (es != 0);
    e.sw    = (esw != 0);
    e.id    = step_id;
    sb_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin : stim
    // Reset then idle
    step(A, 1, 0, 0, 0, 0, 0, 0);
    step(A, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(A, 0, 0, 0, 0, 0, 0, 0);

    // Single requester on channel 1, then release: s stays 1 in idle
    step(A, 0, 0, 1, 0, 1, 1, 1);
    for (int i = 0; i < 4; i++) step(A, 0, 0, 1, 0, 1, 1, 0);
    step(A, 0, 0, 0, 0, 0, 1, 0);
    step(A, 0, 0, 0, 0, 0, 1, 0);

    // Tie after reset: channel 0 first, then hand-over with no idle gap
    step(A, 1, 0, 0, 0, 0, 0, 0);
    step(A, 0, 1, 1, 1, 0, 0, 1);
    step(A, 0, 1, 1, 1, 0, 0, 0);
    step(A, 0, 1, 1, 1, 0, 0, 0);
    step(A, 0, 0, 1, 0, 1, 1, 1);
    step(A, 0, 0, 1, 0, 1, 1, 0);
    step(A, 0, 0, 0, 0, 0, 1, 0);

    // Timeout (MAX_HOLD=4): each owner keeps 4 contended cycles, then yields
    step(A, 0, 1, 0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(A, 0, 1, 1, 1, 0, 0, 0);
    step(A, 0, 1, 1, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) step(A, 0, 1, 1, 0, 1, 1, 0);
    step(A, 0, 1, 1, 1, 0, 0, 1);
    step(A, 0, 0, 0, 0, 0, 0, 0);

    // Reset mid-grant on channel 1, then tie goes to channel 0
    step(A, 0, 0, 1, 0, 1, 1, 1);
    step(A, 0, 0, 1, 0, 1, 1, 0);
    step(A, 1, 0, 1, 0, 0, 0, 0);
    step(A, 0, 1, 1, 1, 0, 0, 1);
    step(A, 0, 0, 0, 0, 0, 0, 0);

    // Reset mid-grant on channel 0 must restore last=1 (tie -> channel 0)
    step(A, 0, 1, 0, 1, 0, 0, 1);
    step(A, 1, 1, 0, 0, 0, 0, 0);
    step(A, 0, 1, 1, 1, 0, 0, 1);
    step(A, 0, 0, 0, 0, 0, 0, 0);

    // Timeout disabled: channel 0 keeps the mux under 40 cycles of contention
    step(B, 0, 1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 40; i++) step(B, 0, 1, 1, 1, 0, 0, 0);
    step(B, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
